mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM stage of the 5-stage MIPS pipeline. Consumes the EXE/MEM pipeline register outputs.
//  Performs load/store through a req/ack data-memory handshake, stalling upstream while busy.
//  Produces the registered MEM/WB bundle (writeback data, dest reg, write enable, valid).
//  Also provides an access timeout and sticky error reporting.
// PARAMETERS
//  DSIZE    32  data/address width (matches `DSIZE in define.v)
//  ASIZE    5   register-file address width (matches `ASIZE)
//  TIMEOUT  15  max cycles in WAIT without dmem_ack before abort (>=2)
// PORTS
//  clk          in   1      clock, all state on posedge
//  rst_n        in   1      async active-low reset
//  valid_in     in   1      EXE/MEM holds a real instruction
//  aluout_in    in   DSIZE  ALU result; memory address for ld/st
//  rdata2_in    in   DSIZE  store data
//  waddr_in     in   ASIZE  destination register
//  wen_in       in   1      regfile write enable
//  MemWrite_in  in   1      store
//  memtoreg_in  in   1      load (writeback takes memory data)
//  stall        out  1      freeze EXE/MEM and earlier stages (combinational)
//  dmem_req     out  1      memory request (registered)
//  dmem_we      out  1      1=write, 0=read; valid while dmem_req
//  dmem_addr    out  DSIZE  byte address, word aligned
//  dmem_wdata   out  DSIZE  store data
//  dmem_rdata   in   DSIZE  load data, valid with dmem_ack
//  dmem_ack     in   1      single-cycle completion pulse
//  wb_data      out  DSIZE  MEM/WB writeback data
//  waddr_out    out  ASIZE  MEM/WB destination register
//  wen_out      out  1      MEM/WB write enable (already qualified by valid_out)
//  valid_out    out  1      MEM/WB holds a completed instruction (1-cycle pulse per instr)
//  mem_err      out  1      sticky: misaligned access or timeout seen
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, timeout counter=0, every output register=0;
//   stall=0 while in reset.
//  MEM op = valid_in & (MemWrite_in | memtoreg_in). MemWrite_in & memtoreg_in both 1 = store.
//  Non-mem op in IDLE: next edge writes wb_data=aluout_in, waddr_out, wen_out=wen_in,
//   valid_out=1. Latency 1, no stall.
//  Bubble (valid_in=0): next edge valid_out=0, wen_out=0.
//  States:
//   IDLE -> WAIT when MEM op and aluout_in[1:0]==0. That edge latches dmem_addr, dmem_we,
//    dmem_wdata, waddr, wen, load flag, sets dmem_req=1 and valid_out=0.
//   IDLE, misaligned MEM op: no request; next edge sets mem_err=1 and valid_out=1 with
//    wen_out=0; stays IDLE.
//   WAIT: dmem_req and its fields held stable until ack.
//    On dmem_ack: dmem_req=0, valid_out=1, waddr_out=latched;
//     load  -> wb_data=dmem_rdata, wen_out=latched wen;
//     store -> wb_data=latched addr, wen_out=0. Then WAIT -> IDLE.
//   Timeout counter: cleared on entry to WAIT, +1 each WAIT cycle without ack.
//    At TIMEOUT-1 without ack: abort, dmem_req=0, valid_out=1, wen_out=0, mem_err=1,
//    WAIT -> IDLE.
//  stall = (IDLE & aligned MEM op) | (WAIT & ~dmem_ack). Stall drops in the ack cycle,
//   so a back-to-back MEM op is accepted in IDLE the next cycle (2-cycle min per ld/st).
//  Simultaneous events:
//   ack in the timeout cycle -> ack wins, no error.
//   ack while IDLE -> ignored.
//   Reset mid-WAIT -> request dropped immediately, no writeback.
//  mem_err clears only on reset.
// STRUCTURE
//  define.v (shared): DSIZE, ASIZE, state encodings MEM_IDLE=1'b0, MEM_WAIT=1'b1.
//  Sub-module: mem_timeout_counter (clear/enable/expire, width $clog2(TIMEOUT)).
//  Everything else is local to this module.
// TESTING
//  ALU op aluout_in=0x10, waddr=3, wen=1 -> next cycle wb_data=0x10, waddr_out=3,
//   wen_out=1, valid_out=1, stall never high.
//  Load addr 0x40, ack after 3 cycles with rdata=0xDEADBEEF -> dmem_req high 3 cycles,
//   stall high until ack, then wb_data=0xDEADBEEF, wen_out=1.
//  Store addr 0x44 data 0x55 ack after 1 cycle -> dmem_we=1, dmem_wdata=0x55,
//   valid_out=1, wen_out=0.
//  Load addr 0x42 -> no dmem_req, mem_err=1, valid_out=1, wen_out=0.
//  Load, ack never comes -> dmem_req drops after TIMEOUT-1 WAIT cycles, mem_err=1,
//   wen_out=0; next op proceeds.
//  rst_n low during WAIT -> dmem_req, valid_out, stall all 0 at once; ack right after
//   reset is ignored.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: default widths, FSM encoding, helpers.
package mem_access_stage_pkg;

    localparam int unsigned DSIZE_DEF   = 32;
    localparam int unsigned ASIZE_DEF   = 5;
    localparam int unsigned TIMEOUT_DEF = 15;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts WAIT cycles without an ack; flags the cycle in which the access must be aborted.
module mem_timeout_counter
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire_c
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // Abort on the cycle whose increment would reach TIMEOUT-1.
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 2);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign expire_c = enable & (count == LAST);

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues loads/stores over a req/ack data-memory port, stalls upstream while busy,
// and produces the registered MEM/WB bundle plus a sticky error flag.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned DSIZE   = DSIZE_DEF,
    parameter int unsigned ASIZE   = ASIZE_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [DSIZE-1:0] aluout_in,
    input  logic [DSIZE-1:0] rdata2_in,
    input  logic [ASIZE-1:0] waddr_in,
    input  logic             wen_in,
    input  logic             MemWrite_in,
    input  logic             memtoreg_in,
    output logic             stall,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [DSIZE-1:0] dmem_addr,
    output logic [DSIZE-1:0] dmem_wdata,
    input  logic [DSIZE-1:0] dmem_rdata,
    input  logic             dmem_ack,
    output logic [DSIZE-1:0] wb_data,
    output logic [ASIZE-1:0] waddr_out,
    output logic             wen_out,
    output logic             valid_out,
    output logic             mem_err
);

    mem_state_e       state, state_next;
    logic             req_next, we_next;
    logic [DSIZE-1:0] addr_next, wdata_next, wb_data_next;
    logic [ASIZE-1:0] waddr_next;
    logic             wen_next, valid_next, err_next;

    // Destination info held while the memory access is outstanding.
    logic [ASIZE-1:0] lat_waddr, lat_waddr_next;
    logic             lat_wen, lat_wen_next;
    logic             lat_load, lat_load_next;

    logic mem_op_c, aligned_c, start_c, timeout_c;

    assign mem_op_c  = valid_in & (MemWrite_in | memtoreg_in);
    assign aligned_c = is_word_aligned(aluout_in[1:0]);
    assign start_c   = mem_op_c & aligned_c;

    assign stall = rst_n & (((state == MEM_IDLE) & start_c) |
                            ((state == MEM_WAIT) & ~dmem_ack));

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state == MEM_IDLE),
        .enable   ((state == MEM_WAIT) & ~dmem_ack),
        .expire_c (timeout_c)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= MEM_IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            wb_data    <= '0;
            waddr_out  <= '0;
            wen_out    <= 1'b0;
            valid_out  <= 1'b0;
            mem_err    <= 1'b0;
            lat_waddr  <= '0;
            lat_wen    <= 1'b0;
            lat_load   <= 1'b0;
        end else begin
            state      <= state_next;
            dmem_req   <= req_next;
            dmem_we    <= we_next;
            dmem_addr  <= addr_next;
            dmem_wdata <= wdata_next;
            wb_data    <= wb_data_next;
            waddr_out  <= waddr_next;
            wen_out    <= wen_next;
            valid_out  <= valid_next;
            mem_err    <= err_next;
            lat_waddr  <= lat_waddr_next;
            lat_wen    <= lat_wen_next;
            lat_load   <= lat_load_next;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_next     = state;
        req_next       = dmem_req;
        we_next        = dmem_we;
        addr_next      = dmem_addr;
        wdata_next     = dmem_wdata;
        wb_data_next   = wb_data;
        waddr_next     = waddr_out;
        wen_next       = 1'b0;
        valid_next     = 1'b0;
        err_next       = mem_err;
        lat_waddr_next = lat_waddr;
        lat_wen_next   = lat_wen;
        lat_load_next  = lat_load;

        case (state)
            MEM_IDLE: begin
                if (start_c) begin
                    state_next     = MEM_WAIT;
                    req_next       = 1'b1;
                    we_next        = MemWrite_in;
                    addr_next      = aluout_in;
                    wdata_next     = rdata2_in;
                    lat_waddr_next = waddr_in;
                    lat_wen_next   = wen_in;
                    lat_load_next  = ~MemWrite_in;
                end else if (mem_op_c) begin
                    // Misaligned access: retire without writeback and flag the error.
                    wb_data_next = aluout_in;
                    waddr_next   = waddr_in;
                    valid_next   = 1'b1;
                    err_next     = 1'b1;
                end else if (valid_in) begin
                    wb_data_next = aluout_in;
                    waddr_next   = waddr_in;
                    wen_next     = wen_in;
                    valid_next   = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ack) begin
                    state_next   = MEM_IDLE;
                    req_next     = 1'b0;
                    valid_next   = 1'b1;
                    waddr_next   = lat_waddr;
                    wb_data_next = lat_load ? dmem_rdata : dmem_addr;
                    wen_next     = lat_load & lat_wen;
                end else if (timeout_c) begin
                    state_next = MEM_IDLE;
                    req_next   = 1'b0;
                    valid_next = 1'b1;
                    waddr_next = lat_waddr;
                    err_next   = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed scoreboard bench for mem_access_stage: ALU ops, loads, stores, misalignment,
// timeout, ack/timeout collision and reset during an outstanding access.
module tb_mem_access_stage;

    localparam int TIMEOUT = 15;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic [31:0] aluout_in;
    logic [31:0] rdata2_in;
    logic [4:0]  waddr_in;
    logic        wen_in;
    logic        MemWrite_in;
    logic        memtoreg_in;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic [31:0] wb_data;
    logic [4:0]  waddr_out;
    logic        wen_out;
    logic        valid_out;
    logic        mem_err;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  waddr;
        logic        wen;
        bit          check_data;
    } wb_exp_t;

    wb_exp_t sb[$];
    int      errors = 0;
    int      checks = 0;

    mem_access_stage #(
        .DSIZE   (32),
        .ASIZE   (5),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_in    (valid_in),
        .aluout_in   (aluout_in),
        .rdata2_in   (rdata2_in),
        .waddr_in    (waddr_in),
        .wen_in      (wen_in),
        .MemWrite_in (MemWrite_in),
        .memtoreg_in (memtoreg_in),
        .stall       (stall),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_rdata  (dmem_rdata),
        .dmem_ack    (dmem_ack),
        .wb_data     (wb_data),
        .waddr_out   (waddr_out),
        .wen_out     (wen_out),
        .valid_out   (valid_out),
        .mem_err     (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] rd2,
                         input logic [4:0] wa, input logic we, input logic mw, input logic mtr);
        valid_in    = v;
        aluout_in   = alu;
        rdata2_in   = rd2;
        waddr_in    = wa;
        wen_in      = we;
        MemWrite_in = mw;
        memtoreg_in = mtr;
    endtask

    task automatic bubble();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [31:0] d, input logic [4:0] wa, input logic we, input bit cd);
        wb_exp_t e;
        e.data = d;
        e.waddr = wa;
        e.wen = we;
        e.check_data = cd;
        sb.push_back(e);
    endtask

    // Compare the current MEM/WB bundle against the oldest expected writeback.
    task automatic wb_check(input string tag);
        wb_exp_t e;
        check({tag, "/valid"}, 32'(valid_out), 32'd1);
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s/scoreboard: observed=empty expected=entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.check_data) check({tag, "/data"}, wb_data, e.data);
            check({tag, "/waddr"}, 32'(waddr_out), 32'(e.waddr));
            check({tag, "/wen"}, 32'(wen_out), 32'(e.wen));
        end
    endtask

    initial begin
        int req_cycles;
        bit dropped;
        bit req_held;

        // Reset, with an aligned load presented so stall must still stay low.
        rst_n = 1'b0;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        drive(1'b1, 32'h40, 32'h0, 5'd1, 1'b1, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("rst/stall", 32'(stall), 32'd0);
        check("rst/req", 32'(dmem_req), 32'd0);
        check("rst/valid", 32'(valid_out), 32'd0);
        check("rst/wen", 32'(wen_out), 32'd0);
        check("rst/wb_data", wb_data, 32'h0);
        check("rst/mem_err", 32'(mem_err), 32'd0);
        bubble();
        rst_n = 1'b1;

        // ALU op: one-cycle latency, no stall.
        @(negedge clk);
        drive(1'b1, 32'h10, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0);
        push(32'h10, 5'd3, 1'b1, 1'b1);
        #1 check("alu/stall", 32'(stall), 32'd0);
        @(negedge clk);
        bubble();
        wb_check("alu");
        @(negedge clk);
        check("bubble/valid", 32'(valid_out), 32'd0);
        check("bubble/wen", 32'(wen_out), 32'd0);

        // Ack while idle is ignored.
        dmem_ack = 1'b1;
        dmem_rdata = 32'h1234;
        @(negedge clk);
        dmem_ack = 1'b0;
        check("idle_ack/valid", 32'(valid_out), 32'd0);
        check("idle_ack/req", 32'(dmem_req), 32'd0);

        // Load 0x40, ack in the third WAIT cycle.
        drive(1'b1, 32'h40, 32'h0, 5'd5, 1'b1, 1'b0, 1'b1);
        push(32'hDEADBEEF, 5'd5, 1'b1, 1'b1);
        #1 check("load/stall_issue", 32'(stall), 32'd1);
        req_held = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            req_held &= dmem_req & stall & ~valid_out;
            if (k == 1) begin
                check("load/addr", dmem_addr, 32'h40);
                check("load/we", 32'(dmem_we), 32'd0);
            end
        end
        check("load/req_held", 32'(req_held), 32'd1);
        dmem_ack = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        #1 check("load/stall_ack", 32'(stall), 32'd0);
        @(negedge clk);
        dmem_ack = 1'b0;
        check("load/req_drop", 32'(dmem_req), 32'd0);
        wb_check("load");

        // Back-to-back store 0x44 data 0x55, ack after one cycle.
        drive(1'b1, 32'h44, 32'h55, 5'd7, 1'b1, 1'b1, 1'b0);
        push(32'h44, 5'd7, 1'b0, 1'b1);
        @(negedge clk);
        check("store/req", 32'(dmem_req), 32'd1);
        check("store/we", 32'(dmem_we), 32'd1);
        check("store/addr", dmem_addr, 32'h44);
        check("store/wdata", dmem_wdata, 32'h55);
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        wb_check("store");

        // MemWrite and memtoreg both set behaves as a store.
        drive(1'b1, 32'h48, 32'hA5, 5'd8, 1'b1, 1'b1, 1'b1);
        push(32'h48, 5'd8, 1'b0, 1'b1);
        @(negedge clk);
        check("both/we", 32'(dmem_we), 32'd1);
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        wb_check("both");

        // Misaligned load.
        drive(1'b1, 32'h42, 32'h0, 5'd2, 1'b1, 1'b0, 1'b1);
        push(32'h0, 5'd2, 1'b0, 1'b0);
        #1 check("misal/stall", 32'(stall), 32'd0);
        @(negedge clk);
        bubble();
        check("misal/req", 32'(dmem_req), 32'd0);
        check("misal/mem_err", 32'(mem_err), 32'd1);
        wb_check("misal");
        repeat (3) @(negedge clk);
        check("err_sticky", 32'(mem_err), 32'd1);

        rst_n = 1'b0;
        #1 check("err_reset", 32'(mem_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load with no ack: abort after TIMEOUT-1 WAIT cycles.
        drive(1'b1, 32'h80, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1);
        push(32'h0, 5'd6, 1'b0, 1'b0);
        req_cycles = 0;
        dropped = 1'b0;
        for (int k = 0; k < TIMEOUT + 4 && !dropped; k++) begin
            @(negedge clk);
            if (dmem_req) req_cycles++;
            else dropped = 1'b1;
        end
        check("timeout/dropped", 32'(dropped), 32'd1);
        check("timeout/req_cycles", 32'(req_cycles), 32'(TIMEOUT - 1));
        check("timeout/mem_err", 32'(mem_err), 32'd1);
        wb_check("timeout");
        drive(1'b1, 32'h20, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0);
        push(32'h20, 5'd9, 1'b1, 1'b1);
        @(negedge clk);
        bubble();
        wb_check("after_timeout");

        // Reset mid-WAIT: request dropped at once, ack right after reset ignored.
        @(negedge clk);
        drive(1'b1, 32'hC0, 32'h0, 5'd10, 1'b1, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("rstwait/req_before", 32'(dmem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstwait/req", 32'(dmem_req), 32'd0);
        check("rstwait/valid", 32'(valid_out), 32'd0);
        check("rstwait/stall", 32'(stall), 32'd0);
        @(negedge clk);
        bubble();
        dmem_ack = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        check("rstwait/ack_valid", 32'(valid_out), 32'd0);
        check("rstwait/ack_req", 32'(dmem_req), 32'd0);
        check("rstwait/mem_err", 32'(mem_err), 32'd0);

        // Ack arriving in the timeout cycle wins.
        drive(1'b1, 32'h100, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1);
        push(32'hCAFEF00D, 5'd4, 1'b1, 1'b1);
        req_held = 1'b1;
        for (int k = 1; k <= TIMEOUT - 2; k++) begin
            @(negedge clk);
            req_held &= dmem_req;
        end
        check("ackwin/req_held", 32'(req_held), 32'd1);
        @(negedge clk);
        dmem_ack = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        dmem_ack = 1'b0;
        bubble();
        wb_check("ackwin");
        check("ackwin/mem_err", 32'(mem_err), 32'd0);

        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
